// File: rtl/mmap_wr_ctrl.sv
// -----------------------------------------------------------------------------
// mmap_wr_ctrl
//
// Store side of the memory-mapped I/O block. CPU stores to the UART TX data
// register are queued in a small byte FIFO, which drains to the UART
// transmitter over a valid/ready handshake. A store to the counter-reset
// register gives a one-cycle pulse that clears the cycle and instruction
// counters. FIFO status is exported for the MMIO status word.
//
// Optional build macro:
//   MMAP_WR_OVF_EN - when defined, tx_overflow is a sticky flag that is set
//                    whenever a TX byte is dropped because the FIFO is full.
//                    An internal 8-bit saturating drop counter is also kept
//                    for debug. Both clear on rst or a counter-reset store.
//                    When undefined, tx_overflow is tied low.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   MMap_We        CPU store to the MMIO region this cycle
//   MMap_Sel[2:0]  MMIO register select (same encoding as the read mux)
//   MMap_din[31:0] store data; only [7:0] is used for TX bytes
//   tx_data[7:0]   byte at the FIFO head, presented to the UART transmitter
//   tx_valid       tx_data is valid
//   tx_ready_in    UART transmitter accepts tx_data on this edge
//   tx_fifo_ready  FIFO can accept another byte (status bit 0)
//   tx_fifo_empty  FIFO holds no entries
//   counters_rst   one-cycle pulse clearing the cycle/instruction counters
//   tx_overflow    sticky dropped-byte flag (0 unless MMAP_WR_OVF_EN)
// -----------------------------------------------------------------------------
module mmap_wr_ctrl #(
  parameter int         TX_DEPTH    = 4,
  parameter logic [2:0] SEL_TX      = 3'd2,
  parameter logic [2:0] SEL_CNT_RST = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MMap_We,
  input  logic [2:0]  MMap_Sel,
  input  logic [31:0] MMap_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready_in,
  output logic        tx_fifo_ready,
  output logic        tx_fifo_empty,
  output logic        counters_rst,
  output logic        tx_overflow
);

  localparam int                PTR_W     = $clog2(TX_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(TX_DEPTH);

  logic [7:0]       mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic sel_tx_we;
  logic cnt_rst_we;
  logic push;
  logic pop;

  // Upper store bits carry no meaning for the TX register.
  logic [23:0] unused_din_hi;
  assign unused_din_hi = MMap_din[31:8];

  // Fullness is judged on the count before the edge, so a push against a
  // full FIFO is dropped even when a pop frees a slot on the same edge.
  assign full       = (count == DEPTH_CNT);
  assign sel_tx_we  = MMap_We && (MMap_Sel == SEL_TX);
  assign cnt_rst_we = MMap_We && (MMap_Sel == SEL_CNT_RST);
  assign push       = sel_tx_we && !full;
  assign pop        = tx_valid && tx_ready_in;

  // NOTE: all state below uses non-blocking (<=) assignments so every
  // register samples pre-edge values; blocking here would create ordering
  // races between the pointer, count and storage updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because TX_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; a flushed FIFO has
  // count 0, and tx_data is forced to 0 while empty, so stale entries can
  // never be observed.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= MMap_din[7:0];
  end

  // Counter-reset pulse: one cycle per store, back-to-back stores give
  // back-to-back pulses.
  always_ff @(posedge clk) begin
    if (rst) counters_rst <= 1'b0;
    else     counters_rst <= cnt_rst_we;
  end

  // Head of queue comes straight from registered storage; no path from
  // MMap_din reaches tx_data in the same cycle.
  assign tx_valid      = (count != '0);
  assign tx_fifo_empty = (count == '0);
  assign tx_fifo_ready = !full;
  assign tx_data       = tx_valid ? mem[rd_ptr] : 8'h00;

`ifdef MMAP_WR_OVF_EN
  logic       drop;
  logic       ovf_q;
  logic [7:0] drop_cnt;

  assign drop = sel_tx_we && full;

  always_ff @(posedge clk) begin
    if (rst || cnt_rst_we) begin
      ovf_q    <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign tx_overflow = ovf_q;
`else
  assign tx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mmap_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmap_wr_ctrl
//
// Self-checking bench for mmap_wr_ctrl. Bytes expected on the UART side are
// queued when the accepting store is driven; a negedge monitor pops and
// compares on every handshake and also checks that a stalled byte is held.
// Scenario tasks check status outputs inline. Expected overflow behaviour
// follows MMAP_WR_OVF_EN.
// -----------------------------------------------------------------------------
module tb_mmap_wr_ctrl;

  localparam logic [2:0] SEL_TX      = 3'd2;
  localparam logic [2:0] SEL_CNT_RST = 3'd5;

`ifdef MMAP_WR_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MMap_We = 1'b0;
  logic [2:0]  MMap_Sel = 3'd0;
  logic [31:0] MMap_din = 32'h0;
  logic        tx_ready_in = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_fifo_ready;
  logic        tx_fifo_empty;
  logic        counters_rst;
  logic        tx_overflow;

  mmap_wr_ctrl #(
    .TX_DEPTH    (4),
    .SEL_TX      (SEL_TX),
    .SEL_CNT_RST (SEL_CNT_RST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .MMap_We       (MMap_We),
    .MMap_Sel      (MMap_Sel),
    .MMap_din      (MMap_din),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready_in   (tx_ready_in),
    .tx_fifo_ready (tx_fifo_ready),
    .tx_fifo_empty (tx_fifo_empty),
    .counters_rst  (counters_rst),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data)
          $display("FAIL hold: got valid=%b data=%h, required valid=1 data=%h",
                   tx_valid, tx_data, prev_data);
        else n_pass++;
      end
      if (tx_valid === 1'b1 && tx_ready_in === 1'b1) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_byte: got %h, required no byte (queue empty)", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp)
            $display("FAIL tx_byte: got %h, required %h", tx_data, mon_exp);
          else n_pass++;
        end
      end
    end
    prev_stall = !rst && (tx_valid === 1'b1) && (tx_ready_in === 1'b0);
    prev_data  = tx_data;
  end

  // All tasks start and end just after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [2:0] sel, input logic [31:0] d);
    MMap_We  = 1'b1;
    MMap_Sel = sel;
    MMap_din = d;
    tick();
    MMap_We  = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL %s: got %0d bytes outstanding, required 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", tx_valid); else n_pass++;
    n_total++; if (tx_fifo_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", tx_fifo_ready); else n_pass++;
    n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b required 1", tx_fifo_empty); else n_pass++;
    n_total++; if (counters_rst !== 1'b0) $display("FAIL reset_cnt_rst: got %b required 0", counters_rst); else n_pass++;
    n_total++; if (tx_overflow !== 1'b0) $display("FAIL reset_ovf: got %b required 0", tx_overflow); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %h required 00", tx_data); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    tx_ready_in = 1'b1;
    exp_q.push_back(8'h41);
    drive_store(SEL_TX, 32'h1234_5641);
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b1) $display("FAIL single_valid: got %b required 1", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 8'h41) $display("FAIL single_data: got %h required 41", tx_data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL single_valid_after: got %b required 0", tx_valid); else n_pass++;
    n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL single_empty_after: got %b required 1", tx_fifo_empty); else n_pass++;
    tick();
  endtask

  task automatic test_fill_stall();
    tx_ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      drive_store(SEL_TX, 32'(i));
    end
    @(negedge clk);
    n_total++; if (tx_fifo_ready !== 1'b0) $display("FAIL fill_ready: got %b required 0", tx_fifo_ready); else n_pass++;
    n_total++; if (tx_data !== 8'h01) $display("FAIL fill_head: got %h required 01", tx_data); else n_pass++;
    tick();
    drive_store(SEL_TX, 32'h0000_0005);
    @(negedge clk);
    n_total++; if (tx_fifo_ready !== 1'b0) $display("FAIL drop_ready: got %b required 0", tx_fifo_ready); else n_pass++;
    n_total++; if (tx_overflow !== OVF_ON) $display("FAIL drop_ovf: got %b required %b", tx_overflow, OVF_ON); else n_pass++;
    tick();
    tx_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL stall_drain_empty: got %b required 1", tx_fifo_empty); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL stall_drain_count: got %0d outstanding required 0", exp_q.size()); else n_pass++;
    tick();
  endtask

  task automatic test_full_pop();
    tx_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      drive_store(SEL_TX, 32'h10 + 32'(i));
    end
    // Full FIFO, pop and push on the same edge: the push is dropped.
    tx_ready_in = 1'b1;
    drive_store(SEL_TX, 32'h0000_00AA);
    tx_ready_in = 1'b0;
    @(negedge clk);
    n_total++; if (tx_fifo_ready !== 1'b1) $display("FAIL fullpop_ready: got %b required 1", tx_fifo_ready); else n_pass++;
    n_total++; if (tx_data !== 8'h11) $display("FAIL fullpop_head: got %h required 11", tx_data); else n_pass++;
    n_total++; if (tx_overflow !== OVF_ON) $display("FAIL fullpop_ovf: got %b required %b", tx_overflow, OVF_ON); else n_pass++;
    tick();
    tx_ready_in = 1'b1;
    drain(10, "fullpop_drain");
    // Hold two entries, then stream with a pop on every edge across several wraps.
    tx_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      drive_store(SEL_TX, 32'h20 + 32'(i));
    end
    tx_ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      drive_store(SEL_TX, 32'hFFFF_FF30 + 32'(i));
    end
    tick();
    tick();
    @(negedge clk);
    n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL stream_empty: got %b required 1", tx_fifo_empty); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL stream_count: got %0d outstanding required 0", exp_q.size()); else n_pass++;
    tick();
  endtask

  task automatic test_counter_reset();
    logic [2:0] ro_sel[6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7};
    tx_ready_in = 1'b0;
    drive_store(SEL_CNT_RST, 32'hFFFF_FFFF);
    @(negedge clk);
    n_total++; if (counters_rst !== 1'b1) $display("FAIL cnt_pulse: got %b required 1", counters_rst); else n_pass++;
    n_total++; if (tx_overflow !== 1'b0) $display("FAIL cnt_ovf_clear: got %b required 0", tx_overflow); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (counters_rst !== 1'b0) $display("FAIL cnt_pulse_end: got %b required 0", counters_rst); else n_pass++;
    tick();
    // Two back-to-back stores.
    MMap_We  = 1'b1;
    MMap_Sel = SEL_CNT_RST;
    MMap_din = 32'h0;
    tick();
    @(negedge clk);
    n_total++; if (counters_rst !== 1'b1) $display("FAIL cnt_b2b_first: got %b required 1", counters_rst); else n_pass++;
    tick();
    MMap_We = 1'b0;
    @(negedge clk);
    n_total++; if (counters_rst !== 1'b1) $display("FAIL cnt_b2b_second: got %b required 1", counters_rst); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (counters_rst !== 1'b0) $display("FAIL cnt_b2b_end: got %b required 0", counters_rst); else n_pass++;
    tick();
    // Read-only selects must not push or pulse.
    foreach (ro_sel[i]) begin
      drive_store(ro_sel[i], 32'hA5A5_A5A5);
      @(negedge clk);
      n_total++; if (counters_rst !== 1'b0) $display("FAIL ro_pulse sel=%0d: got %b required 0", ro_sel[i], counters_rst); else n_pass++;
      n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL ro_empty sel=%0d: got %b required 1", ro_sel[i], tx_fifo_empty); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    tx_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      drive_store(SEL_TX, 32'h61 + 32'(i));
    end
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", tx_valid); else n_pass++;
    n_total++; if (tx_fifo_empty !== 1'b1) $display("FAIL midrst_empty: got %b required 1", tx_fifo_empty); else n_pass++;
    n_total++; if (tx_fifo_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", tx_fifo_ready); else n_pass++;
    tick();
    tx_ready_in = 1'b1;
    exp_q.push_back(8'h7E);
    drive_store(SEL_TX, 32'h0000_007E);
    @(negedge clk);
    n_total++; if (tx_data !== 8'h7E) $display("FAIL midrst_first: got %h required 7e", tx_data); else n_pass++;
    tick();
    drain(4, "midrst_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_fill_stall();
    test_full_pop();
    test_counter_reset();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
